// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (port 0) and data (port 1).
// Data wins ties; a streak counter forces a fetch grant after MAX_STREAK data wins.
module mem_port_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    output logic        done0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    output logic        done1,
    output logic [31:0] rdata1,
    output logic        sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          done0_nxt, done1_nxt, sel_nxt, mem_req_nxt, mem_we_nxt;
    logic [31:0]   rdata0_nxt, rdata1_nxt, mem_addr_nxt, mem_wdata_nxt;
    logic          grant1;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            sel       <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
            sel       <= sel_nxt;
            mem_req   <= mem_req_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= mem_we_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;
        sel_nxt       = sel;
        mem_req_nxt   = mem_req;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt    = mem_we;
        grant1        = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant1      = req1 && !(req0 && (streak == SW'(MAX_STREAK)));
                    sel_nxt     = grant1;
                    mem_req_nxt = 1'b1;
                    state_nxt   = BUSY;
                    if (grant1) begin
                        mem_addr_nxt  = addr1;
                        mem_wdata_nxt = wdata1;
                        mem_we_nxt    = we1;
                        // Count only data wins that made fetch wait
                        if (!req0)
                            streak_nxt = '0;
                        else if (streak != SW'(MAX_STREAK))
                            streak_nxt = streak + SW'(1);
                    end else begin
                        mem_addr_nxt  = addr0;
                        mem_wdata_nxt = '0;
                        mem_we_nxt    = 1'b0;
                        streak_nxt    = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = DONE;
                    if (sel) begin
                        done1_nxt = 1'b1;
                        if (!mem_we)
                            rdata1_nxt = mem_rdata;
                    end else begin
                        done0_nxt = 1'b1;
                        if (!mem_we)
                            rdata0_nxt = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder with
// configurable ack latency, scenario tasks with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;
    logic        done0, done1, sel, mem_req, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .done1(done1), .rdata1(rdata1),
        .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for mem_req; timeout counts as a failed comparison
    task automatic wait_req(input string name);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL %s: mem_req=%b required 1 within 20 cycles", name, mem_req);
        end
    endtask

    // Called just after mem_req is seen; ack sampled k edges after the grant edge
    task automatic serve(input int k, input logic [31:0] d);
        repeat (k - 1) step();
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        total++;
        if ({sel, mem_req, mem_we, done0, done1} !== 5'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: sel=%b req=%b we=%b d0=%b d1=%b addr=%h wd=%h r0=%h r1=%h required all 0",
                     sel, mem_req, mem_we, done0, done1, mem_addr, mem_wdata, rdata0, rdata1);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (mem_req !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle_req: cycle %0d mem_req=%b required 0", i, mem_req);
            end
        end
    endtask

    task automatic test_fetch_read();
        req0  = 1'b1;
        addr0 = 32'h0040_0000;
        wait_req("fetch_grant");
        total++;
        if (sel !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL fetch_bus: sel=%b we=%b addr=%h wd=%h required 0 0 00400000 00000000",
                     sel, mem_we, mem_addr, mem_wdata);
        end
        serve(3, 32'h8C22_0004);
        total++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || mem_req !== 1'b0 || rdata0 !== 32'h8C22_0004) begin
            bad++;
            $display("FAIL fetch_done: d0=%b d1=%b req=%b r0=%h required 1 0 0 8c220004",
                     done0, done1, mem_req, rdata0);
        end
        req0 = 1'b0;
        step();
        total++;
        if (done0 !== 1'b0 || rdata0 !== 32'h8C22_0004) begin
            bad++;
            $display("FAIL fetch_pulse: d0=%b r0=%h required 0 8c220004", done0, rdata0);
        end
    endtask

    task automatic test_data_write();
        // A read first so the following write has a nonzero rdata1 to preserve
        req1  = 1'b1;
        addr1 = 32'h1001_0004;
        we1   = 1'b0;
        wait_req("data_read_grant");
        serve(2, 32'h55AA_0001);
        total++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || rdata1 !== 32'h55AA_0001) begin
            bad++;
            $display("FAIL data_read_done: d1=%b d0=%b r1=%h required 1 0 55aa0001", done1, done0, rdata1);
        end
        req1 = 1'b0;
        step();
        req1   = 1'b1;
        addr1  = 32'h1001_0000;
        wdata1 = 32'hDEAD_BEEF;
        we1    = 1'b1;
        wait_req("data_write_grant");
        total++;
        if (sel !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1001_0000 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_bus: sel=%b we=%b addr=%h wd=%h required 1 1 10010000 deadbeef",
                     sel, mem_we, mem_addr, mem_wdata);
        end
        serve(2, 32'h1234_5678);
        total++;
        if (done1 !== 1'b1 || rdata1 !== 32'h55AA_0001 || rdata0 !== 32'h8C22_0004) begin
            bad++;
            $display("FAIL write_done: d1=%b r1=%h r0=%h required 1 55aa0001 8c220004", done1, rdata1, rdata0);
        end
        req1 = 1'b0;
        we1  = 1'b0;
        step();
        total++;
        if (done1 !== 1'b0) begin
            bad++;
            $display("FAIL write_pulse: d1=%b required 0", done1);
        end
    endtask

    task automatic test_starvation();
        logic exp_sel;
        addr0 = 32'h0040_0100;
        addr1 = 32'h1001_0100;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_sel = (i % 5 == 4) ? 1'b0 : 1'b1;
            wait_req("starve_grant");
            total++;
            if (sel !== exp_sel) begin
                bad++;
                $display("FAIL starve_order: grant %0d sel=%b required %b", i, sel, exp_sel);
            end
            serve(1, 32'h0000_1000 + 32'(i));
            total++;
            if (done1 !== exp_sel || done0 !== ~exp_sel) begin
                bad++;
                $display("FAIL starve_done: grant %0d d0=%b d1=%b required %b %b",
                         i, done0, done1, ~exp_sel, exp_sel);
            end
            if (i == 9) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            step();
        end
        total++;
        if (rdata0 !== 32'h0000_1009 || rdata1 !== 32'h0000_1008) begin
            bad++;
            $display("FAIL starve_rdata: r0=%h r1=%h required 00001009 00001008", rdata0, rdata1);
        end
    endtask

    task automatic test_stray_ack();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        step();
        total++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || mem_req !== 1'b0 ||
            rdata0 !== 32'h0000_1009 || rdata1 !== 32'h0000_1008) begin
            bad++;
            $display("FAIL stray_idle: d0=%b d1=%b req=%b r0=%h r1=%h required 0 0 0 00001009 00001008",
                     done0, done1, mem_req, rdata0, rdata1);
        end
        req1  = 1'b1;
        addr1 = 32'h1001_0008;
        we1   = 1'b0;
        wait_req("drop_grant");
        req1 = 1'b0;
        serve(3, 32'hCAFE_F00D);
        total++;
        if (done1 !== 1'b1 || rdata1 !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL drop_done: d1=%b r1=%h required 1 cafef00d", done1, rdata1);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        total++;
        if (done1 !== 1'b0 || done0 !== 1'b0 || mem_req !== 1'b0 || rdata1 !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL stray_done: d0=%b d1=%b req=%b r1=%h required 0 0 0 cafef00d",
                     done0, done1, mem_req, rdata1);
        end
        step();
    endtask

    task automatic test_reset_busy();
        req0  = 1'b1;
        addr0 = 32'h0040_0010;
        wait_req("rst_grant");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (mem_req !== 1'b0 || sel !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 ||
            mem_addr !== 32'h0 || rdata0 !== 32'h0) begin
            bad++;
            $display("FAIL rst_busy: req=%b sel=%b d0=%b d1=%b addr=%h r0=%h required 0 0 0 0 0 0",
                     mem_req, sel, done0, done1, mem_addr, rdata0);
        end
        step();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0040_0010 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_regrant: req=%b addr=%h d0=%b required 1 00400010 0", mem_req, mem_addr, done0);
        end
        serve(2, 32'h1111_2222);
        total++;
        if (done0 !== 1'b1 || rdata0 !== 32'h1111_2222) begin
            bad++;
            $display("FAIL rst_serve: d0=%b r0=%h required 1 11112222", done0, rdata0);
        end
        req0 = 1'b0;
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch_read();
        test_data_write();
        test_starvation();
        test_stray_ack();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
